// File: rtl/ycbcr_to_rgb_pipe.sv
// ycbcr_to_rgb_pipe: 3-stage BT.601 studio-range YCbCr to RGB converter with valid/ready and frame-last sideband
module ycbcr_to_rgb_pipe (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_last,
  input  logic [7:0] Y,
  input  logic [7:0] Cb,
  input  logic [7:0] Cr,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic [7:0] R,
  output logic [7:0] G,
  output logic [7:0] B
);
  logic stall, v1, v2, l1, l2;
  logic signed [8:0] y1, cb1, cr1;
  logic signed [19:0] ye, cbe, cre, r2, g2, b2;
  assign stall = out_valid & ~out_ready;
  assign in_ready = ~stall;
  assign ye = 20'(y1);
  assign cbe = 20'(cb1);
  assign cre = 20'(cr1);
  function automatic logic [7:0] sat(input logic signed [19:0] x);
    logic signed [19:0] t;
    t = (x + 20'sd128) >>> 8;
    return t[19] ? 8'd0 : (|t[18:8]) ? 8'hff : t[7:0];
  endfunction
  always_ff @(posedge clk) begin
    if (!rst) begin
      {v1, v2, l1, l2, out_valid, out_last} <= '0;
      {y1, cb1, cr1} <= '0;
      {r2, g2, b2} <= '0;
      {R, G, B} <= '0;
    end else if (!stall) begin
      v1 <= in_valid;
      l1 <= in_last;
      y1 <= $signed({1'b0, Y}) - 9'sd16;
      cb1 <= $signed({1'b0, Cb}) - 9'sd128;
      cr1 <= $signed({1'b0, Cr}) - 9'sd128;
      v2 <= v1;
      l2 <= l1;
      r2 <= 20'sd298 * ye + 20'sd409 * cre;
      g2 <= 20'sd298 * ye - 20'sd100 * cbe - 20'sd208 * cre;
      b2 <= 20'sd298 * ye + 20'sd516 * cbe;
      out_valid <= v2;
      out_last <= l2;
      R <= sat(r2);
      G <= sat(g2);
      B <= sat(b2);
    end
  end
endmodule
